// File: rtl/aoc_types_pkg.sv
// Shared types and defaults for the top-K sorting stage.
package aoc_types_pkg;

  localparam logic SORT_MIN = 1'b0;
  localparam logic SORT_MAX = 1'b1;

  localparam int KEY_W_DEF = 34;
  localparam int IDX_W_DEF = 10;

  typedef enum logic {FILL, DRAIN} topk_state_e;

endpackage

// File: rtl/topk_sorter_cell.sv
// One sorter slot: valid/entry registers plus the comparator that tells the
// neighbour below whether an incoming entry lands at or above this slot.
module topk_cell
  import aoc_types_pkg::*;
#(
  parameter int KEY_W        = KEY_W_DEF,
  parameter int ENT_W        = KEY_W_DEF + 2 * IDX_W_DEF,
  parameter int TIE_NEW_LAST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_max,
  input  logic             load_new,
  input  logic             load_above,
  input  logic             load_below,
  input  logic [ENT_W-1:0] new_ent,
  input  logic             above_vld,
  input  logic [ENT_W-1:0] above_ent,
  input  logic             below_vld,
  input  logic [ENT_W-1:0] below_ent,
  output logic             vld,
  output logic [ENT_W-1:0] ent,
  output logic             new_better
);

  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] new_key;
  logic             ahead;

  assign key     = ent[ENT_W-1 -: KEY_W];
  assign new_key = new_ent[ENT_W-1 -: KEY_W];

  // A held entry stays ahead of the newcomer when it is better, or equal with stable ties.
  always_comb begin
    ahead = 1'b0;
    if (vld) begin
      if (mode_max == SORT_MAX)
        ahead = (key > new_key) || ((TIE_NEW_LAST != 0) && (key == new_key));
      else
        ahead = (key < new_key) || ((TIE_NEW_LAST != 0) && (key == new_key));
    end
  end

  assign new_better = ~ahead;

  always_ff @(posedge clk) begin
    if (rst)             vld <= 1'b0;
    else if (load_new)   vld <= 1'b1;
    else if (load_above) vld <= above_vld;
    else if (load_below) vld <= below_vld;
  end

  always_ff @(posedge clk) begin
    if (load_new)        ent <= new_ent;
    else if (load_above) ent <= above_ent;
    else if (load_below) ent <= below_ent;
  end

endmodule

// File: rtl/topk_sorter.sv
// Bounded top-K insertion sorter with ready/valid input and best-first drain.
// Optional drop counter output is enabled by defining TOPK_SORTER_DROP_CNT_EN.
module topk_sorter
  import aoc_types_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int KEY_W        = KEY_W_DEF,
  parameter int IDX_W        = IDX_W_DEF,
  parameter int TIE_NEW_LAST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode_max,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [KEY_W-1:0]           in_key,
  input  logic [IDX_W-1:0]           in_idx_a,
  input  logic [IDX_W-1:0]           in_idx_b,
  input  logic                       flush,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [KEY_W-1:0]           out_key,
  output logic [IDX_W-1:0]           out_idx_a,
  output logic [IDX_W-1:0]           out_idx_b,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done
`ifdef TOPK_SORTER_DROP_CNT_EN
  ,
  output logic [31:0]                drop_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = KEY_W + 2 * IDX_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
  } entry_t;

  topk_state_e      state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             done_nxt;
  logic             mode_q;
  logic             accept, pop, full;
  entry_t           new_ent;
  entry_t           ents [DEPTH];
  logic [DEPTH-1:0] vlds;
  logic [DEPTH-1:0] new_better;

  assign in_rdy  = (state == FILL) && !rst;
  assign accept  = in_vld && in_rdy;
  assign pop     = (state == DRAIN) && out_rdy;
  assign full    = (count == FULL);
  assign new_ent = '{key: in_key, idx_a: in_idx_a, idx_b: in_idx_b};

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    case (state)
      FILL: begin
        if (accept && !full) count_nxt = count + ONE;
        // A same-cycle insert counts toward the drain, so only a truly empty flush is a no-op.
        if (flush) begin
          if (accept || (count != '0)) state_nxt = DRAIN;
          else                         done_nxt  = 1'b1;
        end
      end
      DRAIN: begin
        if (pop) begin
          count_nxt = count - ONE;
          if (count == ONE) begin
            state_nxt = FILL;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      count  <= '0;
      done   <= 1'b0;
      mode_q <= SORT_MIN;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
      if ((state == FILL) && (count == '0)) mode_q <= mode_max;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic   above_vld, below_vld, ld_new, ld_above;
    entry_t above_ent, below_ent;

    // The insert point is the first slot where the newcomer wins; slots below it shift down.
    if (i == 0) begin : g_first
      assign above_vld = 1'b0;
      assign above_ent = '0;
      assign ld_new    = accept && new_better[0];
      assign ld_above  = 1'b0;
    end else begin : g_rest
      assign above_vld = vlds[i-1];
      assign above_ent = ents[i-1];
      assign ld_new    = accept && new_better[i] && !new_better[i-1];
      assign ld_above  = accept && new_better[i] && new_better[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign below_vld = 1'b0;
      assign below_ent = '0;
    end else begin : g_inner
      assign below_vld = vlds[i+1];
      assign below_ent = ents[i+1];
    end

    topk_cell #(
      .KEY_W        (KEY_W),
      .ENT_W        (ENT_W),
      .TIE_NEW_LAST (TIE_NEW_LAST)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .mode_max   (mode_q),
      .load_new   (ld_new),
      .load_above (ld_above),
      .load_below (pop),
      .new_ent    (new_ent),
      .above_vld  (above_vld),
      .above_ent  (above_ent),
      .below_vld  (below_vld),
      .below_ent  (below_ent),
      .vld        (vlds[i]),
      .ent        (ents[i]),
      .new_better (new_better[i])
    );
  end

  assign out_vld   = (state == DRAIN);
  assign out_last  = out_vld && (count == ONE);
  assign out_key   = out_vld ? ents[0].key   : '0;
  assign out_idx_a = out_vld ? ents[0].idx_a : '0;
  assign out_idx_b = out_vld ? ents[0].idx_b : '0;

`ifdef TOPK_SORTER_DROP_CNT_EN
  // Every accept while full either discards the input or evicts the worst slot.
  always_ff @(posedge clk) begin
    if (rst)                                     drop_cnt <= '0;
    else if (accept && full && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_topk_sorter.sv
// Directed bench for topk_sorter (DEPTH=4) with a reference model feeding an expected-output queue.
module tb_topk_sorter;

  localparam int DEPTH = 4;
  localparam int KEY_W = 34;
  localparam int IDX_W = 10;

  typedef struct {
    logic [KEY_W-1:0] key;
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;
    logic             last;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst, mode_max, in_vld, in_rdy, flush, out_vld, out_rdy, out_last, done;
  logic [KEY_W-1:0] in_key, out_key;
  logic [IDX_W-1:0] in_idx_a, in_idx_b, out_idx_a, out_idx_b;
  logic [2:0]       count;
`ifdef TOPK_SORTER_DROP_CNT_EN
  logic [31:0]      drop_cnt;
`endif

  ent_t mq[$];
  ent_t exp_q[$];
  logic mmode = 1'b0;
  int   mdrop = 0;
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  topk_sorter #(.DEPTH(DEPTH), .KEY_W(KEY_W), .IDX_W(IDX_W), .TIE_NEW_LAST(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_max  (mode_max),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_key    (in_key),
    .in_idx_a  (in_idx_a),
    .in_idx_b  (in_idx_b),
    .flush     (flush),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_key   (out_key),
    .out_idx_a (out_idx_a),
    .out_idx_b (out_idx_b),
    .out_last  (out_last),
    .count     (count),
    .done      (done)
`ifdef TOPK_SORTER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: position is the count of held keys ranked at or ahead of the new key.
  function automatic void model_ins(input logic [KEY_W-1:0] k, input logic [IDX_W-1:0] a,
                                    input logic [IDX_W-1:0] b);
    int   p = 0;
    ent_t e;
    if (mq.size() == 0) mmode = mode_max;
    foreach (mq[i]) if (mmode ? (mq[i].key >= k) : (mq[i].key <= k)) p++;
    e = '{k, a, b, 1'b0};
    if (mq.size() == DEPTH) begin
      mdrop++;
      if (p == DEPTH) return;
    end
    mq.insert(p, e);
    if (mq.size() > DEPTH) void'(mq.pop_back());
  endfunction

  function automatic void load_exp();
    ent_t e;
    while (mq.size() > 0) begin
      e = mq.pop_front();
      e.last = (mq.size() == 0);
      exp_q.push_back(e);
    end
  endfunction

  task automatic ins(input logic [KEY_W-1:0] k, input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    in_vld = 1'b1; in_key = k; in_idx_a = a; in_idx_b = b;
    check("in_rdy_fill", in_rdy, 1);
    model_ins(k, a, b);
    step();
    in_vld = 1'b0;
    check("count_ins", count, mq.size());
  endtask

  task automatic do_flush();
    flush = 1'b1;
    load_exp();
    step();
    flush = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int   cyc = 0;
    ent_t e;
    while (exp_q.size() > 0 && cyc < 64) begin
      out_rdy = bp ? ((cyc % 3) == 0) : 1'b1;
      e = exp_q[0];
      check("out_vld", out_vld, 1);
      check("in_rdy_drain", in_rdy, 0);
      check("out_key", out_key, e.key);
      check("out_idx_a", out_idx_a, e.a);
      check("out_idx_b", out_idx_b, e.b);
      check("out_last", out_last, e.last);
      if (out_rdy) void'(exp_q.pop_front());
      step();
      cyc++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check("done_pulse", done, 1);
    check("out_vld_end", out_vld, 0);
    check("count_end", count, 0);
    check("in_rdy_end", in_rdy, 1);
    out_rdy = 1'b1;
    step();
    check("done_clear", done, 0);
  endtask

  initial begin
    ent_t e;
    rst = 1'b1; mode_max = 1'b0; in_vld = 1'b0; in_key = '0; in_idx_a = '0; in_idx_b = '0;
    flush = 1'b0; out_rdy = 1'b1;

    // Reset state
    step();
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_last", out_last, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_out_key", out_key, 0);
    step();
    rst = 1'b0;
    #1;
    check("in_rdy_idle", in_rdy, 1);

    // Min mode with eviction, discard, tie ordering, drained under backpressure
    mode_max = 1'b0;
    ins(34'd50, 10'd1, 10'd11);
    ins(34'd20, 10'd2, 10'd12);
    ins(34'd70, 10'd3, 10'd13);
    ins(34'd20, 10'd9, 10'd14);
    ins(34'd10, 10'd5, 10'd15);
    ins(34'd90, 10'd6, 10'd16);
    check("count_full", count, 4);
    do_flush();
    drain(1'b1);
`ifdef TOPK_SORTER_DROP_CNT_EN
    check("drop_cnt_t1", drop_cnt, mdrop);
`endif

    // Max mode; mode change after first insert must be ignored
    mode_max = 1'b1;
    ins(34'd5, 10'd1, 10'd0);
    mode_max = 1'b0;
    ins(34'd9, 10'd2, 10'd0);
    ins(34'd1, 10'd3, 10'd0);
    ins(34'd9, 10'd4, 10'd0);
    ins(34'd3, 10'd5, 10'd0);
    do_flush();
    drain(1'b0);
`ifdef TOPK_SORTER_DROP_CNT_EN
    check("drop_cnt_t2", drop_cnt, mdrop);
`endif

    // Insert in the same cycle as flush joins the drain
    mode_max = 1'b0;
    ins(34'd12, 10'd1, 10'd2);
    ins(34'd30, 10'd3, 10'd4);
    ins(34'd40, 10'd5, 10'd6);
    in_vld = 1'b1; in_key = 34'd7; in_idx_a = 10'd7; in_idx_b = 10'd8;
    flush = 1'b1;
    model_ins(34'd7, 10'd7, 10'd8);
    load_exp();
    step();
    in_vld = 1'b0; flush = 1'b0;
    check("count_same_cycle", count, 4);
    drain(1'b0);

    // Empty flush
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("empty_done", done, 1);
    check("empty_out_vld", out_vld, 0);
    check("empty_in_rdy", in_rdy, 1);
    step();
    check("empty_done_clear", done, 0);
    check("empty_out_vld2", out_vld, 0);

    // Reset in the middle of a drain
    ins(34'd8, 10'd1, 10'd1);
    ins(34'd6, 10'd2, 10'd2);
    ins(34'd4, 10'd3, 10'd3);
    ins(34'd2, 10'd4, 10'd4);
    do_flush();
    out_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      check("mid_out_key", out_key, e.key);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    mq.delete();
    mdrop = 0;
    #1;
    check("mid_rst_out_vld", out_vld, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_in_rdy", in_rdy, 1);
`ifdef TOPK_SORTER_DROP_CNT_EN
    check("mid_rst_drop_cnt", drop_cnt, 0);
`endif
    ins(34'd3, 10'd7, 10'd7);
    do_flush();
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
